// File: rtl/rf_multiport.sv
// rf_multiport: multi-ported register file with a per-register busy scoreboard.
// Register 0 always reads zero. Each read port can optionally see same-cycle
// write data and busy-clears through a bypass network.
//
// Interface timing: reads (o_rdata, o_rbusy) are purely combinational from
// the address inputs. Writes (i_wen/i_waddr/i_wdata) and allocations
// (i_alloc_en/i_alloc_addr) are sampled at posedge i_clk and take effect
// from the next cycle. There is no valid/ready handshake: every enabled
// write or alloc is accepted unconditionally.
module rf_multiport #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,  // power of two, at least 2
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int BYPASS_EN = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_RD*AW-1:0]   i_raddr,
  output logic [NUM_RD*XLEN-1:0] o_rdata,
  output logic [NUM_RD-1:0]      o_rbusy,
  input  logic [NUM_WR-1:0]      i_wen,
  input  logic [NUM_WR*AW-1:0]   i_waddr,
  input  logic [NUM_WR*XLEN-1:0] i_wdata,
  input  logic                   i_alloc_en,
  input  logic [AW-1:0]          i_alloc_addr,
  output logic [DEPTH-1:0]       o_busy_vec
);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Storage update: later (higher-index) write ports overwrite earlier ones
  // on an address collision because their non-blocking update lands last.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wen[j] && (i_waddr[j*AW +: AW] != '0)) begin
          mem[i_waddr[j*AW +: AW]] <= i_wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Next busy state: writes clear, alloc sets afterwards so a new producer
  // supersedes a retiring one on the same register; bit 0 never goes busy.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_wen[j]) begin
        busy_nxt[i_waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (i_alloc_en) begin
      busy_nxt[i_alloc_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign o_busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            hit;

    assign ra = i_raddr[k*AW +: AW];

    // Read mux: array contents, overridden by the highest-index matching
    // enabled write port. Writes in a reset cycle are dropped, so they are
    // not forwarded either.
    always_comb begin
      rd  = mem[ra];
      hit = 1'b0;
      if ((BYPASS_EN != 0) && !i_rst) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (i_wen[j] && (i_waddr[j*AW +: AW] == ra)) begin
            rd  = i_wdata[j*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
      end
    end

    assign o_rdata[k*XLEN +: XLEN] = (ra == '0) ? '0 : rd;
    assign o_rbusy[k]              = (ra != '0) && busy[ra] && !hit;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed test of rf_multiport in three configurations:
// default with bypass, default without bypass (same stimulus), and a
// 16 x 64-bit, 2-read / 1-write instance.
module tb_rf_multiport;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [19:0]  raddr;
  logic [1:0]   wen;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic         alloc_en;
  logic [4:0]   alloc_addr;
  logic [127:0] rdata_a, rdata_b;
  logic [3:0]   rbusy_a, rbusy_b;
  logic [31:0]  bv_a, bv_b;

  logic [7:0]   c_raddr;
  logic         c_wen;
  logic [3:0]   c_waddr;
  logic [63:0]  c_wdata;
  logic         c_alloc_en;
  logic [3:0]   c_alloc_addr;
  logic [127:0] c_rdata;
  logic [1:0]   c_rbusy;
  logic [15:0]  c_bv;

  rf_multiport #(.BYPASS_EN(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_a), .o_rbusy(rbusy_a),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_alloc_en(alloc_en),
    .i_alloc_addr(alloc_addr), .o_busy_vec(bv_a)
  );

  rf_multiport #(.BYPASS_EN(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_b), .o_rbusy(rbusy_b),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_alloc_en(alloc_en),
    .i_alloc_addr(alloc_addr), .o_busy_vec(bv_b)
  );

  rf_multiport #(.XLEN(64), .DEPTH(16), .NUM_RD(2), .NUM_WR(1), .BYPASS_EN(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_raddr(c_raddr), .o_rdata(c_rdata), .o_rbusy(c_rbusy),
    .i_wen(c_wen), .i_waddr(c_waddr), .i_wdata(c_wdata), .i_alloc_en(c_alloc_en),
    .i_alloc_addr(c_alloc_addr), .o_busy_vec(c_bv)
  );

  // ---------------- scoreboard ----------------
  // Output selectors for expected entries.
  localparam int S_RD_A = 0, S_RB_A = 1, S_BV_A = 2;
  localparam int S_RD_B = 3, S_RB_B = 4, S_BV_B = 5;
  localparam int S_RD_C = 6, S_RB_C = 7, S_BV_C = 8;

  logic [63:0] exp_q[$];
  int          sel_q[$];
  int          port_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [63:0] actual(input int s, input int p);
    case (s)
      S_RD_A:  return {32'h0, rdata_a[p*32 +: 32]};
      S_RB_A:  return {63'h0, rbusy_a[p]};
      S_BV_A:  return {32'h0, bv_a};
      S_RD_B:  return {32'h0, rdata_b[p*32 +: 32]};
      S_RB_B:  return {63'h0, rbusy_b[p]};
      S_BV_B:  return {32'h0, bv_b};
      S_RD_C:  return c_rdata[p*64 +: 64];
      S_RB_C:  return {63'h0, c_rbusy[p]};
      default: return {48'h0, c_bv};
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, mid-cycle, and every
  // expectation queued for this cycle is checked against them.
  always @(negedge clk) begin : monitor
    logic [63:0] e, a;
    int          s, p;
    string       t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      p = port_q.pop_front();
      t = tag_q.pop_front();
      a = actual(s, p);
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s port%0d: got 0x%0h expected 0x%0h", t, p, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int s, input int p, input logic [63:0] v, input string t);
    exp_q.push_back(v);
    sel_q.push_back(s);
    port_q.push_back(p);
    tag_q.push_back(t);
  endtask

  // Expect the same value on all four ports of a default-size instance.
  task automatic push4(input int s, input logic [63:0] v, input string t);
    for (int k = 0; k < 4; k++) push(s, k, v, t);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen        = '0;
    alloc_en   = 1'b0;
    c_wen      = 1'b0;
    c_alloc_en = 1'b0;
  endtask

  task automatic rd_all(input logic [4:0] a);
    for (int k = 0; k < 4; k++) raddr[k*5 +: 5] = a;
  endtask

  task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
    wen[j]            = 1'b1;
    waddr[j*5 +: 5]   = a;
    wdata[j*32 +: 32] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    raddr        = '0;
    waddr        = '0;
    wdata        = '0;
    alloc_addr   = '0;
    c_raddr      = '0;
    c_waddr      = '0;
    c_wdata      = '0;
    c_alloc_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: sweep every register across the four ports.
    push(S_BV_A, 0, 64'h0, "reset_busy_vec_a");
    push(S_BV_B, 0, 64'h0, "reset_busy_vec_b");
    push(S_BV_C, 0, 64'h0, "reset_busy_vec_c");
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        raddr[k*5 +: 5] = 5'(c*4 + k);
        push(S_RD_A, k, 64'h0, "reset_rdata_a");
        push(S_RB_A, k, 64'h0, "reset_rbusy_a");
        push(S_RD_B, k, 64'h0, "reset_rdata_b");
      end
      for (int k = 0; k < 2; k++) begin
        c_raddr[k*4 +: 4] = 4'(c*2 + k);
        push(S_RD_C, k, 64'h0, "reset_rdata_c");
        push(S_RB_C, k, 64'h0, "reset_rbusy_c");
      end
      next_cycle();
    end

    // Single write x5 on port 0: bypass shows it at once, plain array next cycle.
    set_wr(0, 5'd5, 32'hDEADBEEF);
    rd_all(5'd5);
    push4(S_RD_A, 64'hDEADBEEF, "wr_cycle_bypass_x5");
    push4(S_RD_B, 64'h0, "wr_cycle_nobypass_x5");
    next_cycle();
    idle();
    push4(S_RD_A, 64'hDEADBEEF, "after_wr_x5_a");
    push4(S_RD_B, 64'hDEADBEEF, "after_wr_x5_b");
    next_cycle();

    // Collision on x7: higher-index port wins both in bypass and in the array.
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    rd_all(5'd7);
    push4(S_RD_A, 64'h22, "collide_bypass_x7");
    push(S_RD_B, 0, 64'h0, "collide_nobypass_x7");
    next_cycle();
    idle();
    push4(S_RD_A, 64'h22, "collide_array_x7_a");
    push4(S_RD_B, 64'h22, "collide_array_x7_b");
    next_cycle();

    // Write to x0 is discarded and never forwarded.
    set_wr(0, 5'd0, 32'hFFFFFFFF);
    rd_all(5'd0);
    push4(S_RD_A, 64'h0, "x0_wr_cycle");
    push(S_RB_A, 0, 64'h0, "x0_rbusy");
    next_cycle();
    idle();
    push4(S_RD_A, 64'h0, "x0_after_wr_a");
    push(S_RD_B, 0, 64'h0, "x0_after_wr_b");
    next_cycle();

    // Alloc x9: invisible in the alloc cycle, busy afterwards.
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    rd_all(5'd9);
    push(S_RB_A, 0, 64'h0, "alloc_cycle_rbusy_x9");
    push(S_BV_A, 0, 64'h0, "alloc_cycle_busy_vec");
    next_cycle();
    idle();
    push(S_BV_A, 0, 64'h200, "after_alloc_busy_vec_a");
    push(S_BV_B, 0, 64'h200, "after_alloc_busy_vec_b");
    push4(S_RB_A, 64'h1, "after_alloc_rbusy_x9_a");
    push(S_RB_B, 2, 64'h1, "after_alloc_rbusy_x9_b");
    next_cycle();

    // Producer writes x9 on port 1: bypass hides busy this cycle, clears at edge.
    set_wr(1, 5'd9, 32'h1234);
    push4(S_RB_A, 64'h0, "wb_cycle_rbusy_x9_a");
    push(S_RB_B, 1, 64'h1, "wb_cycle_rbusy_x9_b");
    push(S_BV_A, 0, 64'h200, "wb_cycle_busy_vec");
    push(S_RD_A, 3, 64'h1234, "wb_cycle_rdata_x9");
    next_cycle();
    idle();
    push(S_BV_A, 0, 64'h0, "after_wb_busy_vec_a");
    push(S_BV_B, 0, 64'h0, "after_wb_busy_vec_b");
    push(S_RB_A, 0, 64'h0, "after_wb_rbusy_x9");
    push(S_RD_B, 0, 64'h1234, "after_wb_rdata_x9");
    next_cycle();

    // Alloc and write x3 together: set wins, data lands.
    alloc_en   = 1'b1;
    alloc_addr = 5'd3;
    set_wr(0, 5'd3, 32'h55);
    rd_all(5'd3);
    push(S_RB_A, 0, 64'h0, "alloc_wr_cycle_rbusy_x3");
    next_cycle();
    idle();
    push(S_BV_A, 0, 64'h8, "alloc_wr_busy_vec_a");
    push(S_BV_B, 0, 64'h8, "alloc_wr_busy_vec_b");
    push4(S_RB_A, 64'h1, "alloc_wr_rbusy_x3");
    push(S_RD_A, 1, 64'h55, "alloc_wr_rdata_x3_a");
    push(S_RD_B, 2, 64'h55, "alloc_wr_rdata_x3_b");
    next_cycle();

    // Alloc x0 is ignored.
    alloc_en   = 1'b1;
    alloc_addr = 5'd0;
    rd_all(5'd0);
    next_cycle();
    idle();
    push(S_BV_A, 0, 64'h8, "alloc_x0_busy_vec");
    push(S_RB_A, 0, 64'h0, "alloc_x0_rbusy");
    next_cycle();

    // Re-alloc of an already busy x3 keeps it busy.
    alloc_en   = 1'b1;
    alloc_addr = 5'd3;
    next_cycle();
    idle();
    push(S_BV_A, 0, 64'h8, "realloc_x3_busy_vec");
    next_cycle();

    // Small instance: 64-bit data on x15, port 1 reading x0.
    c_wen   = 1'b1;
    c_waddr = 4'd15;
    c_wdata = 64'h0123456789ABCDEF;
    c_raddr = {4'd0, 4'd15};
    push(S_RD_C, 0, 64'h0123456789ABCDEF, "c_wr_cycle_bypass_x15");
    push(S_RD_C, 1, 64'h0, "c_x0_port1");
    next_cycle();
    idle();
    c_alloc_en   = 1'b1;
    c_alloc_addr = 4'd15;
    push(S_RD_C, 0, 64'h0123456789ABCDEF, "c_after_wr_x15");
    push(S_RB_C, 0, 64'h0, "c_alloc_cycle_rbusy_x15");
    next_cycle();
    idle();
    push(S_BV_C, 0, 64'h8000, "c_after_alloc_busy_vec");
    push(S_RB_C, 0, 64'h1, "c_after_alloc_rbusy_x15");
    next_cycle();

    // Write x4 and alloc x6, then reset: everything clears at the edge.
    set_wr(0, 5'd4, 32'hA);
    alloc_en   = 1'b1;
    alloc_addr = 5'd6;
    next_cycle();
    idle();
    rd_all(5'd4);
    push(S_RD_A, 0, 64'hA, "pre_reset_rdata_x4");
    push(S_BV_A, 0, 64'h48, "pre_reset_busy_vec");
    next_cycle();
    rst = 1'b1;
    set_wr(0, 5'd4, 32'hB);
    alloc_en   = 1'b1;
    alloc_addr = 5'd7;
    push(S_RD_B, 0, 64'hA, "reset_cycle_rdata_x4_b");
    push(S_BV_A, 0, 64'h48, "reset_cycle_busy_vec");
    next_cycle();
    rst = 1'b0;
    idle();
    push4(S_RD_A, 64'h0, "post_reset_rdata_x4_a");
    push(S_RD_B, 0, 64'h0, "post_reset_rdata_x4_b");
    push(S_BV_A, 0, 64'h0, "post_reset_busy_vec_a");
    push(S_BV_B, 0, 64'h0, "post_reset_busy_vec_b");
    push(S_BV_C, 0, 64'h0, "post_reset_busy_vec_c");
    push(S_RD_C, 0, 64'h0, "post_reset_rdata_c_x15");
    next_cycle();

    // Drain: the monitor must have consumed every expectation.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-issue register file, for the dual-issue pipeline.
- NUM_RD asynchronous read ports and NUM_WR synchronous write ports.
- Configurable width and depth, with register 0 hardwired to zero and optional write-to-read bypass.
- An integrated per-register busy scoreboard lets decode stall on pending producers.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of 2 and at least 2. AW = log2(DEPTH).
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS_EN, 1, when 1, same-cycle write data and busy-clears are visible on the read ports.

Ports:
- i_clk  in  1  global clock.
- i_rst  in  1  synchronous active-high reset.
- i_raddr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- o_rdata  out  NUM_RD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- o_rbusy  out  NUM_RD  per-port flag: the addressed register has a pending producer.
- i_wen  in  NUM_WR  per-port write enable.
- i_waddr  in  NUM_WR*AW  write addresses.
- i_wdata  in  NUM_WR*XLEN  write data.
- i_alloc_en  in  1  mark a destination as pending (issue).
- i_alloc_addr  in  AW  destination being allocated.
- o_busy_vec  out  DEPTH  registered busy bits; bit 0 is always 0.

Behaviour:
- Storage: DEPTH x XLEN array plus busy[DEPTH-1:0].
- Reset, at posedge i_clk while i_rst=1:
  - All registers are cleared to 0 and all busy bits to 0. Writes and allocs in that cycle are ignored.
  - Read ports remain combinational, so o_rdata reflects the array (0 after the reset edge). o_rbusy=0 and o_busy_vec=0 after the reset edge.
- Writes take effect at the posedge after the cycle in which i_wen[j]=1.
  - Writes to address 0 are discarded.
- Write collision: several enabled ports with the same address in one cycle → the highest-index port wins. Ports are independent otherwise.
- Read, combinational, zero latency:
  - raddr=0 → data 0, busy 0, always.
  - BYPASS_EN=0 → o_rdata = array contents.
  - BYPASS_EN=1 → if any enabled write port has waddr=raddr≠0, the read returns the highest-index such port's wdata; otherwise the array contents.
- Scoreboard update at posedge, when not in reset:
  - Each enabled write to address a≠0 clears busy[a].
  - i_alloc_en with alloc_addr a≠0 sets busy[a].
  - Alloc and write-clear to the same address in the same cycle → set wins, because a new producer supersedes.
  - Alloc to address 0 is ignored.
- o_rbusy[k]:
  - BYPASS_EN=0 → busy[raddr_k].
  - BYPASS_EN=1 → busy[raddr_k] AND NOT (a same-cycle enabled write to raddr_k).
  - The same-cycle alloc never affects o_rbusy; it is visible from the next cycle.
- Re-alloc of an already-busy register keeps it busy.
- A write to a non-busy register is legal and updates data only.
- All read ports may address the same register simultaneously; every port gets identical results.
- Reads to an address being reset-cleared return pre-reset contents until the edge (no bypass of reset).
- No X propagation: every output is defined for every input combination once reset has been applied.

Test Plan:
- Reset, then read x0–x31 on all 4 ports → all data 0, o_rbusy=0, o_busy_vec=0.
- Write x5=0xDEADBEEF on port 0; the next cycle read x5 on ports 0–3 → all 0xDEADBEEF.
  - With BYPASS_EN=1, reading x5 in the write cycle also gives 0xDEADBEEF.
  - With BYPASS_EN=0, the write-cycle read gives 0.
- Same cycle: port0 writes x7=0x11, port1 writes x7=0x22 → bypass read returns 0x22, and the array holds 0x22 afterwards.
  - Separately, a write of x0=0xFFFFFFFF → x0 reads 0.
- Alloc x9 → next cycle o_busy_vec[9]=1 and o_rbusy=1 for x9.
  - Then write x9=0x1234 → with BYPASS_EN=1, o_rbusy=0 in that cycle; busy clears at the next edge.
- Alloc x3 and write x3=0x55 in the same cycle → next cycle busy[3]=1 and data=0x55.
  - Alloc x0 → busy[0] stays 0.
- Write x4=0xA and alloc x6, then assert i_rst for one cycle → x4 reads 0 and o_busy_vec=0 after the edge.
  - Repeat with DEPTH=16, XLEN=64, NUM_RD=2, NUM_WR=1: write x15=0x0123456789ABCDEF → reads back 0x0123456789ABCDEF.
